// File: rtl/qdr_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : qdr_traffic_gen
// Purpose  : Self-checking QDR memory traffic generator. Each pass writes a
//            pattern to every word in [addr_lo, addr_hi], then reads the words
//            back and compares them against the same pattern. Passes alternate
//            pattern polarity. Errors are counted and reported as sticky.
// Optional : `define QDR_TG_ERR_CAPTURE_EN adds err_addr/err_exp/err_got.
//            These ports hold the first miscompare seen after start.
// Ports    : clk, rst_n (sync, active-low)
//            control   : cal_done, start, loop, stop, mode, addr_lo, addr_hi
//            write req : wr_cmd, wr_addr, wr_data, wr_bw_n, wr_rdy
//            read req  : rd_cmd, rd_addr, rd_rdy
//            read ret  : rd_valid, rd_data
//            status    : busy, done, compare_error, err_cnt, pass_cnt
// Revision : 1.0 - initial release
// ============================================================================
module qdr_traffic_gen #(
    parameter int DATA_WIDTH = 36,
    parameter int BW_WIDTH   = DATA_WIDTH / 9,
    parameter int ADDR_WIDTH = 18,
    parameter int RD_DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cal_done,
    input  logic                  start,
    input  logic                  loop,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] addr_lo,
    input  logic [ADDR_WIDTH-1:0] addr_hi,
    output logic                  wr_cmd,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [BW_WIDTH-1:0]   wr_bw_n,
    input  logic                  wr_rdy,
    output logic                  rd_cmd,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_rdy,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  compare_error,
    output logic [15:0]           err_cnt,
`ifdef QDR_TG_ERR_CAPTURE_EN
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [DATA_WIDTH-1:0] err_exp,
    output logic [DATA_WIDTH-1:0] err_got,
`endif
    output logic [15:0]           pass_cnt
);

    localparam int c_ptr_w = $clog2(RD_DEPTH);
    localparam int c_rep   = (DATA_WIDTH + ADDR_WIDTH - 1) / ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_CAL = 3'd1,
        WRITE    = 3'd2,
        READ     = 3'd3,
        DRAIN    = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Pattern is purely a function of address and pass parity, so the read
    // side can regenerate the expected word from the queued address alone.
    function automatic logic [DATA_WIDTH-1:0] f_pattern(
        input logic [1:0]            m,
        input logic [ADDR_WIDTH-1:0] a,
        input logic                  p
    );
        logic [c_rep*ADDR_WIDTH-1:0] wide;
        logic [ADDR_WIDTH-1:0]       pos;
        logic [DATA_WIDTH-1:0]       v;
        wide = {c_rep{a}};
        pos  = a % ADDR_WIDTH'(DATA_WIDTH);
        case (m)
            2'd0:    v = wide[DATA_WIDTH-1:0];
            2'd1:    v = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << pos;
            2'd2:    v = ~wide[DATA_WIDTH-1:0];
            default: v = {DATA_WIDTH{a[0]}};
        endcase
        return v ^ {DATA_WIDTH{p}};
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_parity;
    logic                  r_stop_seen;
    logic                  r_cmp_err;
    logic [15:0]           r_err_cnt;
    logic [15:0]           r_pass_cnt;

    logic [ADDR_WIDTH-1:0] r_fifo [RD_DEPTH];
    logic [c_ptr_w-1:0]    r_wptr;
    logic [c_ptr_w-1:0]    r_rptr;
    logic [c_ptr_w:0]      r_count;

    logic                  w_start_acc;
    logic                  w_flush;
    logic                  w_pass_begin;
    logic                  w_drain_exit;
    logic                  w_last;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_ret;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_exp;
    logic                  w_miscmp;

    assign w_last    = (r_addr == addr_hi);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (c_ptr_w+1)'(RD_DEPTH));
    assign w_wr_fire = wr_cmd && wr_rdy;
    assign w_rd_fire = rd_cmd && rd_rdy;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_acc  = 1'b0;
        w_flush      = 1'b0;
        w_pass_begin = 1'b0;
        w_drain_exit = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = WAIT_CAL;
                    w_start_acc = 1'b1;
                end
            end
            WAIT_CAL: begin
                if (addr_lo > addr_hi) begin
                    w_state_nxt = DONE;
                end else if (cal_done) begin
                    w_state_nxt  = WRITE;
                    w_pass_begin = 1'b1;
                end
            end
            WRITE: begin
                if (!cal_done) begin
                    w_state_nxt = IDLE;
                    w_flush     = 1'b1;
                end else if (w_wr_fire && w_last) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                if (!cal_done) begin
                    w_state_nxt = IDLE;
                    w_flush     = 1'b1;
                end else if (w_rd_fire && w_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!cal_done) begin
                    w_state_nxt = IDLE;
                    w_flush     = 1'b1;
                end else if (w_empty) begin
                    w_drain_exit = 1'b1;
                    // A stop arriving in the exit cycle itself still ends the run.
                    if (loop && !(r_stop_seen || stop)) begin
                        w_state_nxt  = WRITE;
                        w_pass_begin = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------- outputs
    assign busy    = (r_state == WAIT_CAL) || (r_state == WRITE) ||
                     (r_state == READ)     || (r_state == DRAIN);
    assign done    = (r_state == DONE);
    assign wr_cmd  = (r_state == WRITE);
    assign wr_addr = wr_cmd ? r_addr : '0;
    assign wr_data = wr_cmd ? f_pattern(mode, r_addr, r_parity) : '0;
    assign wr_bw_n = '0;
    assign rd_cmd  = (r_state == READ) && !w_full;
    assign rd_addr = (r_state == READ) ? r_addr : '0;

    assign compare_error = r_cmp_err;
    assign err_cnt       = r_err_cnt;
    assign pass_cnt      = r_pass_cnt;

    // ------------------------------------------------------ address / pass
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (w_pass_begin) begin
            r_addr <= addr_lo;
        end else if ((r_state == WRITE) && w_wr_fire) begin
            r_addr <= w_last ? addr_lo : r_addr + ADDR_WIDTH'(1);
        end else if ((r_state == READ) && w_rd_fire && !w_last) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_start_acc) begin
            r_parity    <= 1'b0;
            r_stop_seen <= 1'b0;
            r_pass_cnt  <= '0;
        end else begin
            if (stop && busy)  r_stop_seen <= 1'b1;
            if (w_drain_exit) begin
                r_parity   <= ~r_parity;
                r_pass_cnt <= r_pass_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------- outstanding-read FIFO
    // Returns are ignored in IDLE so that late data from an abandoned run
    // (after reset or calibration loss) is neither compared nor counted.
    assign w_ret       = rd_valid && (r_state != IDLE);
    assign w_pop       = w_ret && !w_empty;
    assign w_head_addr = r_fifo[r_rptr];

    always_ff @(posedge clk) begin
        if (w_rd_fire) r_fifo[r_wptr] <= r_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_flush || w_start_acc) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_rd_fire) r_wptr <= r_wptr + c_ptr_w'(1);
            if (w_pop)     r_rptr <= r_rptr + c_ptr_w'(1);
            case ({w_rd_fire, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------- compare
    assign w_exp    = f_pattern(mode, w_head_addr, r_parity);
    assign w_miscmp = w_ret && (w_empty || (rd_data != w_exp));

    always_ff @(posedge clk) begin
        if (!rst_n || w_start_acc) begin
            r_cmp_err <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_miscmp) begin
            r_cmp_err <= 1'b1;
            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

`ifdef QDR_TG_ERR_CAPTURE_EN
    logic                  r_cap_vld;
    logic [ADDR_WIDTH-1:0] r_err_addr;
    logic [DATA_WIDTH-1:0] r_err_exp;
    logic [DATA_WIDTH-1:0] r_err_got;

    // Empty-FIFO errors have no address to attribute, so addr/exp read as 0.
    always_ff @(posedge clk) begin
        if (!rst_n || w_start_acc) begin
            r_cap_vld  <= 1'b0;
            r_err_addr <= '0;
            r_err_exp  <= '0;
            r_err_got  <= '0;
        end else if (w_miscmp && !r_cap_vld) begin
            r_cap_vld  <= 1'b1;
            r_err_addr <= w_empty ? '0 : w_head_addr;
            r_err_exp  <= w_empty ? '0 : w_exp;
            r_err_got  <= rd_data;
        end
    end

    assign err_addr = r_err_addr;
    assign err_exp  = r_err_exp;
    assign err_got  = r_err_got;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qdr_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_qdr_traffic_gen
// Purpose  : Self-checking bench for qdr_traffic_gen. It contains an ideal
//            4-cycle QDR memory model and a write/read-command scoreboard.
//            Expected commands are queued when a run is launched and are
//            checked as the DUT issues them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qdr_traffic_gen;

    localparam int DW = 36;
    localparam int AW = 18;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n, cal_done, start, loop, stop;
    logic [1:0]    mode;
    logic [AW-1:0] addr_lo, addr_hi;
    logic          wr_cmd, wr_rdy, rd_cmd, rd_rdy, rd_valid;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic [BW-1:0] wr_bw_n;
    logic          busy, done, compare_error;
    logic [15:0]   err_cnt, pass_cnt;
`ifdef QDR_TG_ERR_CAPTURE_EN
    logic [AW-1:0] err_addr;
    logic [DW-1:0] err_exp, err_got;
`endif

    always #5 clk = ~clk;

    qdr_traffic_gen #(.DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW), .RD_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cal_done(cal_done), .start(start), .loop(loop),
        .stop(stop), .mode(mode), .addr_lo(addr_lo), .addr_hi(addr_hi),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bw_n(wr_bw_n),
        .wr_rdy(wr_rdy), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
        .compare_error(compare_error), .err_cnt(err_cnt),
`ifdef QDR_TG_ERR_CAPTURE_EN
        .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got),
`endif
        .pass_cnt(pass_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard and memory-model state
    logic [DW-1:0] mem [0:63];
    logic [AW-1:0] exp_wa[$];
    logic [DW-1:0] exp_wd[$];
    logic [AW-1:0] exp_ra[$];
    int unsigned   pend_t[$];
    logic [AW-1:0] pend_a[$];
    int unsigned   cyc = 0;
    int            wr_seen = 0, rd_seen = 0;
    bit            hold_ret = 0, flip_en = 0, flip_now = 0, inject = 0;
    logic [AW-1:0] flip_addr = '0;
    logic [AW-1:0] sb_a, ret_a;
    logic [DW-1:0] sb_d;

    // Reference pattern for the default 36-bit data / 18-bit address build.
    function automatic logic [DW-1:0] tb_pat(input int m, input logic [AW-1:0] a, input bit p);
        logic [DW-1:0] v;
        case (m)
            0:       v = {a, a};
            1:       v = 36'd1 << (a % 36);
            2:       v = ~{a, a};
            default: v = a[0] ? {DW{1'b1}} : {DW{1'b0}};
        endcase
        return p ? ~v : v;
    endfunction

    task automatic push_pass(input int m, input int lo, input int hi, input bit p);
        for (int a = lo; a <= hi; a++) begin
            exp_wa.push_back(AW'(a));
            exp_wd.push_back(tb_pat(m, AW'(a), p));
        end
        for (int a = lo; a <= hi; a++) exp_ra.push_back(AW'(a));
    endtask

    // Memory model + command scoreboard: samples handshakes at the rising
    // edge, drives read returns on the falling edge.
    initial begin : mem_model
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (wr_cmd === 1'b1 && wr_rdy === 1'b1) begin
                wr_seen++;
                mem[wr_addr[5:0]] = wr_data;
                n_checks++;
                if (exp_wa.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_write_unexpected: got addr %0h data %0h, required no write", wr_addr, wr_data);
                end else begin
                    sb_a = exp_wa.pop_front();
                    sb_d = exp_wd.pop_front();
                    if (wr_addr !== sb_a || wr_data !== sb_d || wr_bw_n !== '0) begin
                        n_fail++;
                        $display("FAIL sb_write: got addr %0h data %0h bw_n %0h, required addr %0h data %0h bw_n 0",
                                 wr_addr, wr_data, wr_bw_n, sb_a, sb_d);
                    end
                end
            end
            if (rd_cmd === 1'b1 && rd_rdy === 1'b1) begin
                rd_seen++;
                n_checks++;
                if (exp_ra.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_read_unexpected: got addr %0h, required no read", rd_addr);
                end else begin
                    sb_a = exp_ra.pop_front();
                    if (rd_addr !== sb_a) begin
                        n_fail++;
                        $display("FAIL sb_read: got addr %0h, required %0h", rd_addr, sb_a);
                    end
                end
                pend_t.push_back(cyc + 3);
                pend_a.push_back(rd_addr);
            end
            @(negedge clk);
            rd_valid = 1'b0;
            flip_now = 1'b0;
            if (inject) begin
                inject   = 1'b0;
                rd_valid = 1'b1;
                rd_data  = 36'h5A;
            end else if (!hold_ret && pend_t.size() > 0 && pend_t[0] <= cyc) begin
                void'(pend_t.pop_front());
                ret_a    = pend_a.pop_front();
                rd_valid = 1'b1;
                rd_data  = mem[ret_a[5:0]];
                if (flip_en && ret_a == flip_addr) begin
                    rd_data[3] = ~rd_data[3];
                    flip_now   = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
        pend_t.delete(); pend_a.delete();
        wr_seen = 0; rd_seen = 0; hold_ret = 0; flip_en = 0; inject = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cal_done = 1'b0; start = 1'b0; loop = 1'b0; stop = 1'b0;
        mode = 2'd0; addr_lo = '0; addr_hi = '0; wr_rdy = 1'b1; rd_rdy = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({wr_cmd, rd_cmd, busy, done, compare_error} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b, required 00000", {wr_cmd, rd_cmd, busy, done, compare_error}); end
        n_checks++; if (err_cnt !== 16'd0 || pass_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got err %0d pass %0d, required 0 0", err_cnt, pass_cnt); end
        n_checks++; if (wr_addr !== '0 || rd_addr !== '0 || wr_data !== '0) begin n_fail++; $display("FAIL reset_bus: got wa %0h ra %0h wd %0h, required 0", wr_addr, rd_addr, wr_data); end
`ifdef QDR_TG_ERR_CAPTURE_EN
        n_checks++; if (err_addr !== '0 || err_exp !== '0 || err_got !== '0) begin n_fail++; $display("FAIL reset_capture: got %0h %0h %0h, required 0", err_addr, err_exp, err_got); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        cal_done = 1'b1; mode = 2'd0; addr_lo = 18'd0; addr_hi = 18'd7;
        push_pass(0, 0, 7, 0);
        start_pulse();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, required 1", busy); end
        wait_done(200);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b, required 1 (timeout)", done); end
        n_checks++; if (wr_seen !== 8 || rd_seen !== 8) begin n_fail++; $display("FAIL basic_cmds: got wr %0d rd %0d, required 8 8", wr_seen, rd_seen); end
        n_checks++; if (err_cnt !== 16'd0 || compare_error !== 1'b0) begin n_fail++; $display("FAIL basic_err: got cnt %0d err %b, required 0 0", err_cnt, compare_error); end
        n_checks++; if (pass_cnt !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_pass: got pass %0d busy %b, required 1 0", pass_cnt, busy); end
    endtask

    // Return with an empty FIFO while parked in DONE.
    task automatic test_spurious_return();
        inject = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (err_cnt !== 16'd1 || compare_error !== 1'b1) begin n_fail++; $display("FAIL spurious_err: got cnt %0d err %b, required 1 1", err_cnt, compare_error); end
`ifdef QDR_TG_ERR_CAPTURE_EN
        n_checks++; if (err_addr !== '0 || err_exp !== '0 || err_got !== 36'h5A) begin n_fail++; $display("FAIL spurious_capture: got %0h %0h %0h, required 0 0 5a", err_addr, err_exp, err_got); end
`endif
    endtask

    task automatic test_miscompare();
        bit seen;
        do_reset();
        cal_done = 1'b1; mode = 2'd0; addr_lo = 18'd0; addr_hi = 18'd7;
        flip_en = 1'b1; flip_addr = 18'd5;
        push_pass(0, 0, 7, 0);
        start_pulse();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); #1;
            if (flip_now) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL miscmp_return: got no flipped return, required one (timeout)"); end
        n_checks++; if (compare_error !== 1'b0) begin n_fail++; $display("FAIL miscmp_early: got %b, required 0 during rd_valid cycle", compare_error); end
        @(negedge clk); #1;
        n_checks++; if (compare_error !== 1'b1 || err_cnt !== 16'd1) begin n_fail++; $display("FAIL miscmp_latency: got err %b cnt %0d, required 1 1", compare_error, err_cnt); end
        wait_done(200);
        n_checks++; if (done !== 1'b1 || err_cnt !== 16'd1 || compare_error !== 1'b1) begin n_fail++; $display("FAIL miscmp_final: got done %b cnt %0d err %b, required 1 1 1", done, err_cnt, compare_error); end
`ifdef QDR_TG_ERR_CAPTURE_EN
        n_checks++; if (err_addr !== 18'd5 || err_exp !== tb_pat(0, 18'd5, 0) || err_got !== (tb_pat(0, 18'd5, 0) ^ 36'h8)) begin n_fail++; $display("FAIL miscmp_capture: got %0h %0h %0h, required 5 %0h %0h", err_addr, err_exp, err_got, tb_pat(0, 18'd5, 0), tb_pat(0, 18'd5, 0) ^ 36'h8); end
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        cal_done = 1'b1; mode = 2'd1; addr_lo = 18'd0; addr_hi = 18'd31;
        hold_ret = 1'b1;
        push_pass(1, 0, 31, 0);
        start_pulse();
        for (int i = 0; i < 400 && rd_seen < 16; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        n_checks++; if (rd_seen !== 16) begin n_fail++; $display("FAIL bp_reads: got %0d accepted, required 16", rd_seen); end
        n_checks++; if (rd_cmd !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_rdcmd: got rd_cmd %b busy %b, required 0 1", rd_cmd, busy); end
        hold_ret = 1'b0;
        wait_done(400);
        n_checks++; if (done !== 1'b1 || rd_seen !== 32) begin n_fail++; $display("FAIL bp_resume: got done %b reads %0d, required 1 32", done, rd_seen); end
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL bp_err: got %0d, required 0", err_cnt); end
    endtask

    task automatic test_loop_stop();
        do_reset();
        cal_done = 1'b1; mode = 2'd3; addr_lo = 18'd0; addr_hi = 18'd3; loop = 1'b1;
        push_pass(3, 0, 3, 0);
        push_pass(3, 0, 3, 1);
        push_pass(3, 0, 3, 0);
        start_pulse();
        for (int i = 0; i < 400 && wr_seen < 9; i++) @(negedge clk);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        wait_done(400);
        n_checks++; if (done !== 1'b1 || pass_cnt !== 16'd3) begin n_fail++; $display("FAIL loop_done: got done %b pass %0d, required 1 3", done, pass_cnt); end
        n_checks++; if (wr_seen !== 12 || rd_seen !== 12) begin n_fail++; $display("FAIL loop_cmds: got wr %0d rd %0d, required 12 12", wr_seen, rd_seen); end
        n_checks++; if (err_cnt !== 16'd0 || compare_error !== 1'b0) begin n_fail++; $display("FAIL loop_err: got cnt %0d err %b, required 0 0", err_cnt, compare_error); end
        loop = 1'b0;
    endtask

    task automatic test_bounds();
        do_reset();
        cal_done = 1'b1; mode = 2'd1; addr_lo = 18'd5; addr_hi = 18'd2;
        start_pulse();
        wait_done(50);
        n_checks++; if (done !== 1'b1 || wr_seen !== 0 || rd_seen !== 0 || pass_cnt !== 16'd0) begin n_fail++; $display("FAIL lo_gt_hi: got done %b wr %0d rd %0d pass %0d, required 1 0 0 0", done, wr_seen, rd_seen, pass_cnt); end
        // back-to-back start from DONE with a single-word range
        addr_lo = 18'd9; addr_hi = 18'd9;
        push_pass(1, 9, 9, 0);
        start_pulse();
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart: got done %b busy %b, required 0 1", done, busy); end
        wait_done(100);
        n_checks++; if (done !== 1'b1 || wr_seen !== 1 || rd_seen !== 1 || pass_cnt !== 16'd1 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL lo_eq_hi: got done %b wr %0d rd %0d pass %0d err %0d, required 1 1 1 1 0", done, wr_seen, rd_seen, pass_cnt, err_cnt); end
    endtask

    task automatic test_cal_drop();
        do_reset();
        cal_done = 1'b1; mode = 2'd2; addr_lo = 18'd0; addr_hi = 18'd7;
        push_pass(2, 0, 7, 0);
        start_pulse();
        for (int i = 0; i < 200 && rd_seen < 3; i++) @(negedge clk);
        cal_done = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || rd_cmd !== 1'b0 || wr_cmd !== 1'b0) begin n_fail++; $display("FAIL caldrop_idle: got busy %b done %b rd %b wr %b, required 0 0 0 0", busy, done, rd_cmd, wr_cmd); end
        repeat (12) @(negedge clk);
        n_checks++; if (err_cnt !== 16'd0 || compare_error !== 1'b0) begin n_fail++; $display("FAIL caldrop_late_ret: got cnt %0d err %b, required 0 0", err_cnt, compare_error); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if ({wr_cmd, rd_cmd, busy, done, compare_error} !== 5'b0 || err_cnt !== 16'd0 || pass_cnt !== 16'd0 || wr_addr !== '0 || rd_addr !== '0 || wr_data !== '0) begin n_fail++; $display("FAIL caldrop_reset: got flags %b err %0d pass %0d, required all zero", {wr_cmd, rd_cmd, busy, done, compare_error}, err_cnt, pass_cnt); end
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
        wr_seen = 0; rd_seen = 0;
        cal_done = 1'b1;
        push_pass(2, 0, 7, 0);
        start_pulse();
        wait_done(200);
        n_checks++; if (done !== 1'b1 || err_cnt !== 16'd0 || compare_error !== 1'b0 || pass_cnt !== 16'd1 || rd_seen !== 8) begin n_fail++; $display("FAIL caldrop_rerun: got done %b err %0d cmp %b pass %0d rd %0d, required 1 0 0 1 8", done, err_cnt, compare_error, pass_cnt, rd_seen); end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_basic();
        test_spurious_return();
        test_miscompare();
        test_backpressure();
        test_loop_stop();
        test_bounds();
        test_cal_drop();
        n_checks++; if (exp_wa.size() != 0 || exp_ra.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d writes %0d reads pending, required 0 0", exp_wa.size(), exp_ra.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
